// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctl.sv
// firebird7_in_gate1_tessent_tdr_w19_ctl
// IJTAG test data register that drives the ijtag side of the gate1 data mux.
// The shift path holds one select bit plus WIDTH data bits. Capture samples
// the live functional bus so it can be read back through scan. Update drives
// ijtag_select / ijtag_data_out.
// Optional feature: define FB7_GATE1_TDR_PARITY_EN to add a parity bit at the
// scan-in end of the chain. An update with bad parity is blocked and sets a
// sticky parity_err flag.
module firebird7_in_gate1_tessent_tdr_w19_ctl #(
    parameter int               WIDTH      = 19,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             parity_err
);

`ifdef FB7_GATE1_TDR_PARITY_EN
    localparam int SR_W = WIDTH + 2;
`else
    localparam int SR_W = WIDTH + 1;
`endif

    logic [SR_W-1:0]  sr;
    logic             upd_sel;
    logic [WIDTH-1:0] upd_data;
    logic             upd_ok;
    logic             do_capture;
    logic             do_shift;
    logic             do_update;

    assign do_capture = ijtag_sel & ijtag_ce;
    assign do_shift   = ijtag_sel & ijtag_se;
    assign do_update  = ijtag_sel & ijtag_ue;

    // Shift register: capture has priority over shift; hold otherwise
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            sr <= '0;
        end else if (do_capture) begin
            sr[WIDTH-1:0] <= functional_data_in;
            sr[WIDTH]     <= upd_sel;
`ifdef FB7_GATE1_TDR_PARITY_EN
            sr[WIDTH+1]   <= ^{upd_sel, functional_data_in};
`endif
        end else if (do_shift) begin
            sr <= {ijtag_si, sr[SR_W-1:1]};
        end
    end

`ifdef FB7_GATE1_TDR_PARITY_EN
    // Parity bit must match the XOR of select + data for the update to land
    assign upd_ok = (sr[WIDTH+1] == ^sr[WIDTH:0]);

    logic perr_q;

    // Sticky parity error; only reset clears it
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            perr_q <= 1'b0;
        end else if (do_update && !upd_ok) begin
            perr_q <= 1'b1;
        end
    end

    assign parity_err = perr_q;
`else
    assign upd_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

    // Update registers load the pre-edge shift register contents
    always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
        if (ijtag_reset) begin
            upd_sel  <= 1'b0;
            upd_data <= RESET_DATA;
        end else if (do_update && upd_ok) begin
            {upd_sel, upd_data} <= sr[WIDTH:0];
        end
    end

    // Mux outputs come straight from flops so they never glitch during shift
    assign ijtag_select   = upd_sel;
    assign ijtag_data_out = upd_data;
    assign ijtag_so       = sr[0];

endmodule
